// File: rtl/sr_cmd_pkg.sv
// Shared types and default parameters for the SR flip-flop command sequencer.
package sr_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEB_CYCLES_DEF = 4;
    localparam int HOLDOFF_DEF    = 2;

endpackage

// File: rtl/sr_debounce.sv
// Two-flop synchronizer, stability-count debouncer and rising-edge detector
// for one asynchronous request line.
module sr_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic filt,
    output logic ev
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          filt_r;
    logic          filt_d_r;
    logic [CW-1:0] cnt_r;

    // Synchronize, then flip the filtered level only after an unbroken run of disagreement.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r  <= 1'b0;
            sync2_r  <= 1'b0;
            filt_r   <= 1'b0;
            filt_d_r <= 1'b0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            sync1_r  <= din;
            sync2_r  <= sync1_r;
            filt_d_r <= filt_r;
            if (sync2_r != filt_r) begin
                if (cnt_r == CNT_LAST) begin
                    filt_r <= sync2_r;
                    cnt_r  <= {CW{1'b0}};
                end else begin
                    cnt_r  <= cnt_r + CW'(1);
                end
            end else begin
                cnt_r <= {CW{1'b0}};
            end
        end
    end

    assign filt = filt_r;
    assign ev   = filt_r & ~filt_d_r;

endmodule

// File: rtl/sr_cmd_seq.sv
// Turns debounced set/clear request edges into mutually exclusive one-cycle
// s/r pulses with a hold-off, dropping commands redundant with the mirrored Q.
module sr_cmd_seq
    import sr_cmd_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int HOLDOFF    = HOLDOFF_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic set_req,
    input  logic clr_req,
    output logic s,
    output logic r,
    output logic busy,
    output logic conflict,
    output logic q_mirror
);

    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? (HOLDOFF - 1) : 0);

    state_t        state_r;
    logic [HW-1:0] hold_cnt_r;
    logic          pend_set_r;
    logic          pend_clr_r;
    logic          s_r;
    logic          r_r;
    logic          busy_r;
    logic          conflict_r;
    logic          q_mirror_r;
    logic          ev_set_s;
    logic          ev_clr_s;
    logic          req_set_s;
    logic          req_clr_s;

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_set (
        .clk  (clk),
        .rst  (rst),
        .din  (set_req),
        .filt (),
        .ev   (ev_set_s)
    );

    sr_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk  (clk),
        .rst  (rst),
        .din  (clr_req),
        .filt (),
        .ev   (ev_clr_s)
    );

    assign req_set_s = ev_set_s | pend_set_r;
    assign req_clr_s = ev_clr_s | pend_clr_r;

    // Command FSM: only IDLE can launch a pulse, so s and r can never coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            hold_cnt_r <= {HW{1'b0}};
            pend_set_r <= 1'b0;
            pend_clr_r <= 1'b0;
            s_r        <= 1'b0;
            r_r        <= 1'b0;
            busy_r     <= 1'b0;
            conflict_r <= 1'b0;
            q_mirror_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    pend_set_r <= 1'b0;
                    pend_clr_r <= 1'b0;
                    s_r        <= 1'b0;
                    r_r        <= 1'b0;
                    busy_r     <= 1'b0;
                    conflict_r <= 1'b0;
                    if (req_set_s && req_clr_s) begin
                        conflict_r <= 1'b1;
                    end else if (req_set_s && !q_mirror_r) begin
                        s_r        <= 1'b1;
                        q_mirror_r <= 1'b1;
                        busy_r     <= 1'b1;
                        state_r    <= EMIT;
                    end else if (req_clr_s && q_mirror_r) begin
                        r_r        <= 1'b1;
                        q_mirror_r <= 1'b0;
                        busy_r     <= 1'b1;
                        state_r    <= EMIT;
                    end else begin
                        state_r    <= IDLE;
                    end
                end
                EMIT: begin
                    s_r        <= 1'b0;
                    r_r        <= 1'b0;
                    conflict_r <= 1'b0;
                    pend_set_r <= pend_set_r | ev_set_s;
                    pend_clr_r <= pend_clr_r | ev_clr_s;
                    if (HOLDOFF == 0) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        hold_cnt_r <= {HW{1'b0}};
                        busy_r     <= 1'b1;
                        state_r    <= HOLD;
                    end
                end
                HOLD: begin
                    s_r        <= 1'b0;
                    r_r        <= 1'b0;
                    conflict_r <= 1'b0;
                    pend_set_r <= pend_set_r | ev_set_s;
                    pend_clr_r <= pend_clr_r | ev_clr_s;
                    hold_cnt_r <= hold_cnt_r + HW'(1);
                    if (hold_cnt_r == HOLD_LAST) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        busy_r  <= 1'b1;
                        state_r <= HOLD;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    s_r        <= 1'b0;
                    r_r        <= 1'b0;
                    busy_r     <= 1'b0;
                    conflict_r <= 1'b0;
                    pend_set_r <= 1'b0;
                    pend_clr_r <= 1'b0;
                end
            endcase
        end
    end

    assign s        = s_r;
    assign r        = r_r;
    assign busy     = busy_r;
    assign conflict = conflict_r;
    assign q_mirror = q_mirror_r;

endmodule
